// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types for the hazard/stall controller.
package pipe_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_busy_counter.sv
// Occupancy counter for the multi-cycle mult/div unit: load on start, count down to idle.
module md_busy_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned MULT_CYCLES = pipe_pkg::MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = pipe_pkg::DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_div,
    output logic is_zero
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A start while already busy reloads; the newest operation owns the unit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (load) begin
            state_nxt = MD_BUSY;
            cnt_nxt   = load_div ? DIV_LOAD : MULT_LOAD;
        end else begin
            case (state)
                MD_BUSY: begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = MD_IDLE;
                    end
                end
                default: begin
                    state_nxt = MD_IDLE;
                end
            endcase
        end
    end

    // During reset the count is treated as already drained.
    assign is_zero = reset | (state == MD_IDLE);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller: RAW (Tuse/Tnew) and mult/div occupancy hazards, plus stall counter.
module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = pipe_pkg::MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = pipe_pkg::DIV_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_is_md,
    input  logic [4:0]  e_wa,
    input  logic [1:0]  e_tnew,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_div,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_clr,
    output logic        md_busy,
    output logic        stall,
    output logic [31:0] stall_cnt
);

    logic        raw_rs;
    logic        raw_rt;
    logic        md_stall;
    logic        cnt_zero;
    logic [31:0] stall_cnt_q;

    md_busy_counter #(
        .CNT_W      (CNT_W),
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (e_md_start),
        .load_div(e_md_div),
        .is_zero (cnt_zero)
    );

    always_comb begin
        raw_rs = (d_rs != REG_ZERO) && (d_tuse_rs != TUSE_NONE) &&
                 (((d_rs == e_wa) && (e_tnew > d_tuse_rs)) ||
                  ((d_rs == m_wa) && (m_tnew > d_tuse_rs)));
        raw_rt = (d_rt != REG_ZERO) && (d_tuse_rt != TUSE_NONE) &&
                 (((d_rt == e_wa) && (e_tnew > d_tuse_rt)) ||
                  ((d_rt == m_wa) && (m_tnew > d_tuse_rt)));
    end

    assign md_busy   = e_md_start | ~cnt_zero;
    assign md_stall  = d_is_md & md_busy;
    assign stall     = raw_rs | raw_rt | md_stall;
    assign pc_en     = ~stall;
    assign if_id_en  = ~stall;
    assign id_ex_clr = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
